// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Drives an external combinational 4-bit adder one nibble per cycle. The
// nibbles go LSB first and the carry is chained from one nibble to the next.
// The adder result is collected into a WIDTH-bit sum. The block also returns
// carry-out and two's-complement overflow over a valid/ready handshake.
// Optional feature macro: NIBBLE_ADD_SUB_EN. When it is defined, a 'sub'
// input is added and the block computes A-B by inverting B and seeding the
// carry with 1.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_c,
    input  logic [4:0]       add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last_nib;
    logic [WIDTH-1:0]   b_eff;
    logic               seed;
    logic [3:0]         a_nib [NIB];
    logic [3:0]         b_nib [NIB];

    assign accept   = in_valid && (state_q == IDLE);
    assign last_nib = (idx_q == LAST_IDX);

`ifdef NIBBLE_ADD_SUB_EN
    // Subtraction is A + ~B + 1, so the caller's cin does not apply then.
    assign b_eff = sub ? ~op_b : op_b;
    assign seed  = sub ? 1'b1 : cin;
`else
    assign b_eff = op_b;
    assign seed  = cin;
`endif

    // Split the latched operands into nibble lanes so the RUN mux is a simple array index.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_q[4*gi +: 4];
            assign b_nib[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    // State register and datapath registers; reset may hit at any point, including mid-RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last nibble, DONE -> IDLE on out_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath next values: latch operands on accept, then fold in one adder result per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = op_a;
                    b_d     = b_eff;
                    carry_d = seed;
                    idx_d   = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = add_s[3:0];
                    end
                end
                carry_d = add_s[4];
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    cout_d = add_s[4];
                    // add_s[3] is the sum MSB being written in this same cycle.
                    ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[3] != a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    // Outputs: the handshake flags are decoded from the state; the adder inputs are live only in RUN.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_c     = 1'b0;
        if (state_q == RUN) begin
            add_a = a_nib[idx_q];
            add_b = b_nib[idx_q];
            add_c = carry_q;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (WIDTH=16). It models the external adder
// and keeps an arithmetic reference model. A compare process checks the
// outputs on every falling edge. Directed operations also check hand-computed
// literals.
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          cin = 1'b0;
    logic          sub_sig = 1'b0;
    logic [3:0]    add_a, add_b;
    logic          add_c;
    logic [4:0]    add_s;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout, ovf;

    int checks = 0;
    int failures = 0;

    // Combinational 4-bit carry-in adder stage.
    assign add_s = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c};

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef NIBBLE_ADD_SUB_EN
        .sub       (sub_sig),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: 0=idle, 1=computing (m_k nibbles done), 2=result pending.
    int           m_phase = 0;
    int           m_k = 0;
    logic [31:0]  m_a, m_b, m_c, m_full;
    logic [31:0]  mask;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_sum", 32'(sum), 0);
        end else begin
            case (m_phase)
                0: begin
                    check("idle_in_ready", 32'(in_ready), 1);
                    check("idle_out_valid", 32'(out_valid), 0);
                    check("idle_add_bus", {23'd0, add_c, add_b, add_a}, 0);
                    if (in_valid) begin
                        m_a = 32'(op_a);
                        m_b = 32'(op_b);
                        m_c = 32'(cin);
`ifdef NIBBLE_ADD_SUB_EN
                        if (sub_sig) begin
                            m_b = 32'(~op_b);
                            m_c = 1;
                        end
`endif
                        m_full  = m_a + m_b + m_c;
                        m_phase = 1;
                        m_k     = 0;
                    end
                end
                1: begin
                    check("run_in_ready", 32'(in_ready), 0);
                    check("run_out_valid", 32'(out_valid), 0);
                    check("run_add_a", 32'(add_a), (m_a >> (4 * m_k)) & 32'hF);
                    check("run_add_b", 32'(add_b), (m_b >> (4 * m_k)) & 32'hF);
                    mask = (32'd1 << (4 * m_k)) - 1;
                    check("run_add_c", 32'(add_c), ((m_a & mask) + (m_b & mask) + m_c) >> (4 * m_k));
                    m_k++;
                    if (m_k == NIB) m_phase = 2;
                end
                default: begin
                    check("done_out_valid", 32'(out_valid), 1);
                    check("done_in_ready", 32'(in_ready), 0);
                    check("done_sum", 32'(sum), m_full & 32'hFFFF);
                    check("done_cout", 32'(cout), (m_full >> 16) & 1);
                    check("done_ovf", 32'(ovf),
                          32'((m_a[15] == m_b[15]) && (m_full[15] != m_a[15])));
                    if (out_ready) m_phase = 0;
                end
            endcase
        end
    end

    // One operation. The caller is at posedge+1 with the controller in IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo, input int bp,
                          output logic [3:0] carries);
        int lat;
        carries   = 4'd0;
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        cin       = c;
        sub_sig   = s;
        out_ready = (bp == 0);
        @(posedge clk); #1;
        // Keep in_valid high with junk operands during RUN; the controller must ignore them.
        op_a = 16'hDEAD;
        op_b = 16'hBEEF;
        if (bp == 0) in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) carries[lat] = add_c;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(NIB));
        check("lit_sum", 32'(sum), 32'(es));
        check("lit_cout", 32'(cout), 32'(ec));
        check("lit_ovf", 32'(ovf), 32'(eo));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_sum", 32'(sum), 32'(es));
            check("bp_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("back_idle_in_ready", 32'(in_ready), 1);
        check("back_idle_out_valid", 32'(out_valid), 0);
    endtask

    logic [3:0] cs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_sum", 32'(sum), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 0, cs);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, cs);
        check("lit_carry_chain", 32'(cs), 32'h0000000E);
        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 0, cs);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0, cs);
        run_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 0, cs);
        run_op(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 3, cs);

        // Asynchronous reset while RUN is at idx=2.
        in_valid = 1'b1;
        op_a     = 16'h9999;
        op_b     = 16'h6666;
        cin      = 1'b0;
        sub_sig  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_run_sum_nonzero", 32'(sum != 16'h0000), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_sum", 32'(sum), 0);
        check("async_rst_add_a", 32'(add_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0, cs);

`ifdef NIBBLE_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, cs);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 0, cs);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
